// File: rtl/mc_main_fsm_pkg.sv
// Shared definitions for the multicycle main controller: state encoding,
// opcode constants and the datapath mux select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  // Opcode field values of the supported instructions
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // Immediate format select
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b000;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_main_fsm_if.sv
// Controller <-> datapath/memory signal bundle. The controller side uses
// the master modport; the datapath/memory side uses the slave modport.
interface mc_main_fsm_if;
  logic [6:0] op_code;
  logic       mem_ready;
  logic       pc_update;
  logic       branch;
  logic       reg_write;
  logic       mem_write;
  logic       ir_write;
  logic       adr_src;
  logic       illegal;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic [3:0] state;

  modport master (
    input  op_code, mem_ready,
    output pc_update, branch, reg_write, mem_write, ir_write, adr_src,
           illegal, result_src, alu_src_a, alu_src_b, alu_op, imm_src, state
  );

  modport slave (
    output op_code, mem_ready,
    input  pc_update, branch, reg_write, mem_write, ir_write, adr_src,
           illegal, result_src, alu_src_a, alu_src_b, alu_op, imm_src, state
  );
endinterface

// File: rtl/mc_main_fsm_immdec.sv
// Immediate-format decoder: pure function of the opcode, independent of
// the controller state.
module mc_immdec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op_code,
  output logic [2:0] imm_src
);

  // Map opcode to immediate format; unknown opcodes select 000
  always_comb begin
    imm_src = IMM_NONE;
    case (op_code)
      OP_LW, OP_IALU: imm_src = IMM_I;
      OP_SW:          imm_src = IMM_S;
      OP_BEQ:         imm_src = IMM_B;
      OP_JAL:         imm_src = IMM_J;
      OP_LUI:         imm_src = IMM_U;
      default:        imm_src = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle main controller (Moore FSM). Sequences fetch, decode and the
// per-instruction execute/memory/writeback steps; unknown opcodes park the
// machine in TRAP until reset.
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int EN_LUI  = 1,
  parameter int EN_WAIT = 1
)
(
  input logic           clk,
  input logic           reset,
  mc_main_fsm_if.master bus
);

  state_e     state_r;
  state_e     state_nxt_s;
  logic       ready_s;
  logic [2:0] imm_src_s;

  logic       pc_update_s;
  logic       branch_s;
  logic       reg_write_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       adr_src_s;
  logic       illegal_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;

  // With waiting disabled the memory is treated as always ready
  assign ready_s = (EN_WAIT != 0) ? bus.mem_ready : 1'b1;

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (ready_s) state_nxt_s = S_DECODE;
        else         state_nxt_s = S_FETCH;
      end
      S_DECODE: begin
        case (bus.op_code)
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_RTYP:      state_nxt_s = S_EXECR;
          OP_IALU:      state_nxt_s = S_EXECI;
          OP_BEQ:       state_nxt_s = S_BRANCH;
          OP_JAL:       state_nxt_s = S_JAL;
          OP_LUI: begin
            if (EN_LUI != 0) state_nxt_s = S_LUI;
            else             state_nxt_s = S_TRAP;
          end
          default:      state_nxt_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        // IR is stable here; anything but lw/sw means it was corrupted
        case (bus.op_code)
          OP_LW:   state_nxt_s = S_MEMREAD;
          OP_SW:   state_nxt_s = S_MEMWRITE;
          default: state_nxt_s = S_TRAP;
        endcase
      end
      S_MEMREAD: begin
        if (ready_s) state_nxt_s = S_MEMWB;
        else         state_nxt_s = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (ready_s) state_nxt_s = S_FETCH;
        else         state_nxt_s = S_MEMWRITE;
      end
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_nxt_s = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH:     state_nxt_s = S_FETCH;
      S_TRAP:                         state_nxt_s = S_TRAP;
      default:                        state_nxt_s = S_TRAP;
    endcase
  end

  // Moore output decode; anything not set for a state stays 0
  always_comb begin
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RS2;
    alu_op_s     = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        result_src_s = RES_ALURESULT;
        alu_src_b_s  = SRCB_FOUR;
        ir_write_s   = ready_s;
        pc_update_s  = ready_s;
      end
      S_DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_s = SRCA_RS1;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s = SRCA_RS1;
        alu_op_s    = ALUOP_SUB;
        branch_s    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_FOUR;
        pc_update_s = 1'b1;
      end
      S_LUI: begin
        alu_src_a_s = SRCA_ZERO;
        alu_src_b_s = SRCB_IMM;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Suppress every enable and the trap flag while reset is held; the mux
  // selects already show FETCH values because the state register is FETCH
  always_comb begin
    if (reset) begin
      bus.pc_update = 1'b0;
      bus.branch    = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_write = 1'b0;
      bus.ir_write  = 1'b0;
      bus.illegal   = 1'b0;
    end else begin
      bus.pc_update = pc_update_s;
      bus.branch    = branch_s;
      bus.reg_write = reg_write_s;
      bus.mem_write = mem_write_s;
      bus.ir_write  = ir_write_s;
      bus.illegal   = illegal_s;
    end
  end

  assign bus.adr_src    = adr_src_s;
  assign bus.result_src = result_src_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.imm_src    = imm_src_s;
  assign bus.state      = state_r;

  mc_immdec u_immdec (
    .op_code (bus.op_code),
    .imm_src (imm_src_s)
  );

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: an instruction-level reference model
// (per-opcode step plans, wait steps gated by mem_ready) checked every cycle,
// directed scenarios with literal expectations, randomized traffic, and a
// second instance built with LUI disabled.
module tb_mc_main_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  mc_main_fsm_if bus ();
  mc_main_fsm_if bus2 ();

  mc_main_fsm u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  mc_main_fsm #(.EN_LUI(0)) u_dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       pc, br, rw, mw, ir, adr, ill;
    logic [1:0] res, a, b, aop;
  } exp_t;

  // reference model state
  state_e     m_state;
  state_e     pend[$];
  logic [6:0] cur_op;
  logic       cur_rdy;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] imm_exp(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011: return 3'b000;
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  // Output table straight from the per-state rules; unlisted signals are 0
  function automatic exp_t exp_out(input state_e s, input logic rdy, input logic rst);
    exp_t e;
    e = '0;
    case (s)
      S_FETCH:    begin e.res = 2'b10; e.b = 2'b10; e.ir = rdy; e.pc = rdy; end
      S_DECODE:   begin e.a = 2'b01; e.b = 2'b01; end
      S_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
      S_MEMREAD:  begin e.adr = 1'b1; end
      S_MEMWB:    begin e.res = 2'b01; e.rw = 1'b1; end
      S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      S_EXECR:    begin e.a = 2'b10; e.aop = 2'b10; end
      S_EXECI:    begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
      S_ALUWB:    begin e.rw = 1'b1; end
      S_BRANCH:   begin e.a = 2'b10; e.aop = 2'b01; e.br = 1'b1; end
      S_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pc = 1'b1; end
      S_LUI:      begin e.a = 2'b11; e.b = 2'b01; end
      S_TRAP:     begin e.ill = 1'b1; end
      default:    begin e.ill = 1'b1; end
    endcase
    if (rst) begin
      e = '0;
      e.res = 2'b10;
      e.b   = 2'b10;
    end
    return e;
  endfunction

  // Steps an instruction takes after DECODE
  task automatic set_plan(input logic [6:0] op);
    pend.delete();
    case (op)
      OP_LW:   begin pend.push_back(S_MEMADR); pend.push_back(S_MEMREAD); pend.push_back(S_MEMWB); end
      OP_SW:   begin pend.push_back(S_MEMADR); pend.push_back(S_MEMWRITE); end
      OP_RTYP: begin pend.push_back(S_EXECR); pend.push_back(S_ALUWB); end
      OP_IALU: begin pend.push_back(S_EXECI); pend.push_back(S_ALUWB); end
      OP_BEQ:  pend.push_back(S_BRANCH);
      OP_JAL:  begin pend.push_back(S_JAL); pend.push_back(S_ALUWB); end
      OP_LUI:  begin pend.push_back(S_LUI); pend.push_back(S_ALUWB); end
      default: pend.push_back(S_TRAP);
    endcase
  endtask

  task automatic model_edge();
    if (reset) begin
      m_state = S_FETCH;
      pend.delete();
    end else if (m_state == S_TRAP) begin
      m_state = S_TRAP;
    end else if (m_state == S_DECODE) begin
      set_plan(cur_op);
      m_state = pend.pop_front();
    end else if ((m_state == S_FETCH || m_state == S_MEMREAD || m_state == S_MEMWRITE) && !cur_rdy) begin
      m_state = m_state;
    end else if (m_state == S_FETCH) begin
      m_state = S_DECODE;
    end else if (pend.size() > 0) begin
      m_state = pend.pop_front();
    end else begin
      m_state = S_FETCH;
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = exp_out(m_state, cur_rdy, reset);
    chk("state",      8'(bus.state),      8'(m_state));
    chk("pc_update",  8'(bus.pc_update),  8'(e.pc));
    chk("branch",     8'(bus.branch),     8'(e.br));
    chk("reg_write",  8'(bus.reg_write),  8'(e.rw));
    chk("mem_write",  8'(bus.mem_write),  8'(e.mw));
    chk("ir_write",   8'(bus.ir_write),   8'(e.ir));
    chk("adr_src",    8'(bus.adr_src),    8'(e.adr));
    chk("illegal",    8'(bus.illegal),    8'(e.ill));
    chk("result_src", 8'(bus.result_src), 8'(e.res));
    chk("alu_src_a",  8'(bus.alu_src_a),  8'(e.a));
    chk("alu_src_b",  8'(bus.alu_src_b),  8'(e.b));
    chk("alu_op",     8'(bus.alu_op),     8'(e.aop));
    chk("imm_src",    8'(bus.imm_src),    8'(imm_exp(cur_op)));
  endtask

  // Drive inputs shortly after an edge and compare before the next one
  task automatic apply(input logic [6:0] op, input logic rdy);
    bus.op_code   = op;
    bus.mem_ready = rdy;
    cur_op        = op;
    cur_rdy       = rdy;
    #2;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic latency(input logic [6:0] op, input int exp_cyc, input string name);
    int n;
    n = 0;
    apply(op, 1'b1);
    tick();
    n = 1;
    while (n < 20) begin
      apply(op, 1'b1);
      if (bus.state == S_FETCH) break;
      tick();
      n++;
    end
    chk(name, 8'(n), 8'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    state_e lw_seq[5];
    logic   sw_rdy[7];
    int     cnt_mw, cnt_rw, cnt_br, trap_cnt;
    logic [6:0] rop;
    logic       rrdy, do_rst;
    logic [6:0] legal[7];

    lw_seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
    sw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    legal  = '{OP_LW, OP_SW, OP_RTYP, OP_IALU, OP_BEQ, OP_JAL, OP_LUI};

    reset  = 1'b1;
    reset2 = 1'b1;
    bus2.op_code   = OP_LUI;
    bus2.mem_ready = 1'b1;
    m_state = S_FETCH;
    pend.delete();

    // reset state: enables held low even with mem_ready high
    apply(OP_LW, 1'b1);
    chk("reset_ir_write", 8'(bus.ir_write), 8'd0);
    chk("reset_state", 8'(bus.state), 8'd0);
    chk("reset_alu_src_b", 8'(bus.alu_src_b), 8'd2);
    tick();
    reset = 1'b0;

    // lw, no wait
    for (int k = 0; k < 5; k++) begin
      apply(OP_LW, 1'b1);
      chk("lw_state", 8'(bus.state), 8'(lw_seq[k]));
      chk("lw_reg_write", 8'(bus.reg_write), 8'(k == 4));
      if (k == 4) chk("lw_result_src", 8'(bus.result_src), 8'd1);
      tick();
    end
    apply(OP_LW, 1'b1);
    chk("lw_back_to_fetch", 8'(bus.state), 8'(S_FETCH));

    // sw with three wait cycles in MEMWRITE
    cnt_mw = 0;
    cnt_rw = 0;
    for (int k = 0; k < 7; k++) begin
      apply(OP_SW, sw_rdy[k]);
      cnt_mw += int'(bus.mem_write);
      cnt_rw += int'(bus.reg_write);
      tick();
    end
    apply(OP_SW, 1'b1);
    chk("sw_mem_write_cycles", 8'(cnt_mw), 8'd4);
    chk("sw_reg_write_cycles", 8'(cnt_rw), 8'd0);
    chk("sw_back_to_fetch", 8'(bus.state), 8'(S_FETCH));

    // beq
    cnt_br = 0;
    for (int k = 0; k < 3; k++) begin
      apply(OP_BEQ, 1'b1);
      cnt_br += int'(bus.branch);
      if (k == 2) begin
        chk("beq_state", 8'(bus.state), 8'(S_BRANCH));
        chk("beq_branch", 8'(bus.branch), 8'd1);
        chk("beq_alu_op", 8'(bus.alu_op), 8'd1);
        chk("beq_imm_src", 8'(bus.imm_src), 8'd2);
      end
      tick();
    end
    chk("beq_branch_cycles", 8'(cnt_br), 8'd1);

    // jal
    for (int k = 0; k < 4; k++) begin
      apply(OP_JAL, 1'b1);
      if (k == 2) begin
        chk("jal_state", 8'(bus.state), 8'(S_JAL));
        chk("jal_pc_update", 8'(bus.pc_update), 8'd1);
        chk("jal_imm_src", 8'(bus.imm_src), 8'd3);
      end
      if (k == 3) begin
        chk("jal_wb_state", 8'(bus.state), 8'(S_ALUWB));
        chk("jal_reg_write", 8'(bus.reg_write), 8'd1);
      end
      tick();
    end

    // lui with LUI enabled
    for (int k = 0; k < 4; k++) begin
      apply(OP_LUI, 1'b1);
      if (k == 2) begin
        chk("lui_state", 8'(bus.state), 8'(S_LUI));
        chk("lui_alu_src_a", 8'(bus.alu_src_a), 8'd3);
      end
      if (k == 3) chk("lui_wb_state", 8'(bus.state), 8'(S_ALUWB));
      tick();
    end

    // async reset in MEMWRITE while memory is stalled
    for (int k = 0; k < 3; k++) begin
      apply(OP_SW, 1'b1);
      tick();
    end
    apply(OP_SW, 1'b0);
    chk("abort_pre_mem_write", 8'(bus.mem_write), 8'd1);
    reset = 1'b1;
    m_state = S_FETCH;
    pend.delete();
    #1;
    chk("abort_state", 8'(bus.state), 8'(S_FETCH));
    chk("abort_mem_write", 8'(bus.mem_write), 8'd0);
    check_all();
    tick();
    apply(OP_SW, 1'b1);
    chk("abort_hold_ir_write", 8'(bus.ir_write), 8'd0);
    reset = 1'b0;
    #1;
    chk("abort_release_ir_write", 8'(bus.ir_write), 8'd1);
    tick();
    apply(OP_SW, 1'b1);
    chk("abort_resume_decode", 8'(bus.state), 8'(S_DECODE));
    tick();
    tick();
    apply(OP_SW, 1'b1);
    tick();

    // zero-wait latencies from FETCH entry
    latency(OP_LW,   5, "lat_lw");
    latency(OP_SW,   4, "lat_sw");
    latency(OP_RTYP, 4, "lat_rtype");
    latency(OP_IALU, 4, "lat_ialu");
    latency(OP_JAL,  4, "lat_jal");
    latency(OP_LUI,  4, "lat_lui");
    latency(OP_BEQ,  3, "lat_beq");

    // randomized traffic
    rop = OP_LW;
    trap_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      if (m_state == S_FETCH) begin
        if ($urandom_range(0, 11) == 0) rop = 7'($urandom_range(0, 127));
        else                            rop = legal[$urandom_range(0, 6)];
      end
      rrdy = ($urandom_range(0, 3) != 0);
      if (m_state == S_TRAP) trap_cnt++;
      do_rst = (trap_cnt >= 4) || ($urandom_range(0, 149) == 0);
      if (do_rst) begin
        trap_cnt = 0;
        reset = 1'b1;
        m_state = S_FETCH;
        pend.delete();
      end
      apply(rop, rrdy);
      tick();
      if (do_rst) reset = 1'b0;
    end

    // LUI disabled instance: lui traps and the flag sticks
    chk("nolui_reset_illegal", 8'(bus2.illegal), 8'd0);
    chk("nolui_reset_state", 8'(bus2.state), 8'(S_FETCH));
    reset2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      chk("nolui_state", 8'(bus2.state), 8'(S_TRAP));
      chk("nolui_illegal", 8'(bus2.illegal), 8'd1);
      chk("nolui_enables", 8'({bus2.pc_update, bus2.branch, bus2.reg_write, bus2.mem_write, bus2.ir_write}), 8'd0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 SHALL have parameter EN_LUI, default 1, meaning: decode LUI (0110111) when 1, treat it as illegal when 0.
REQ-002 SHALL have parameter EN_WAIT, default 1, meaning: honour mem_ready when 1, treat mem_ready as constant 1 when 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port op_code, input, 7, opcode field of the instruction register.
REQ-006 SHALL have port mem_ready, input, 1, unified memory has completed the current access.
REQ-007 SHALL have these 1-bit output enables: pc_update, branch, reg_write, mem_write, ir_write.
REQ-008 SHALL have these 1-bit outputs: adr_src (0 = PC, 1 = result) and illegal (sticky trap flag).
REQ-009 SHALL have these 2-bit outputs: result_src (00 = ALUOut, 01 = Data, 10 = ALUResult), alu_src_a (00 = PC, 01 = OldPC, 10 = rs1, 11 = zero), alu_src_b (00 = rs2, 01 = imm, 10 = const 4) and alu_op.
REQ-010 SHALL have output imm_src, 3 bits: I = 000, S = 001, B = 010, J = 011, U = 100.
REQ-011 SHALL have output state, 4 bits, current state encoding for debug.

Function
REQ-012 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP.
REQ-013 Transitions SHALL be:
- FETCH -> DECODE on mem_ready.
- DECODE -> MEMADR on lw or sw; EXECR on R-type; EXECI on I-ALU; BRANCH on beq; JAL on jal; LUI on lui when EN_LUI = 1; TRAP on any other opcode.
- MEMADR -> MEMREAD on lw; MEMADR -> MEMWRITE on sw.
- MEMREAD -> MEMWB on mem_ready.
- MEMWRITE -> FETCH on mem_ready.
- EXECR, EXECI, JAL, LUI -> ALUWB.
- MEMWB, ALUWB, BRANCH -> FETCH.
- TRAP -> TRAP.
REQ-014 FETCH, MEMREAD and MEMWRITE SHALL hold (self-loop) while mem_ready = 0; wait length is unbounded.
REQ-015 FETCH SHALL drive adr_src = 0, a = 00, b = 10, alu_op = 00 and result_src = 10; ir_write and pc_update SHALL equal mem_ready.
REQ-016 DECODE SHALL drive a = 01, b = 01, alu_op = 00.
REQ-017 MEMADR SHALL drive a = 10, b = 01, alu_op = 00.
REQ-018 MEMREAD SHALL drive result_src = 00 and adr_src = 1.
REQ-019 MEMWB SHALL drive result_src = 01 and reg_write = 1.
REQ-020 MEMWRITE SHALL drive result_src = 00 and adr_src = 1, with mem_write = 1 held every cycle until the cycle mem_ready = 1.
REQ-021 EXECR SHALL drive a = 10, b = 00, alu_op = 10.
REQ-022 EXECI SHALL drive a = 10, b = 01, alu_op = 10.
REQ-023 ALUWB SHALL drive result_src = 00 and reg_write = 1.
REQ-024 BRANCH SHALL drive a = 10, b = 00, alu_op = 01, result_src = 00, branch = 1.
REQ-025 JAL SHALL drive a = 01, b = 10, alu_op = 00, result_src = 00, pc_update = 1.
REQ-026 LUI SHALL drive a = 11, b = 01, alu_op = 00.
REQ-027 TRAP SHALL drive illegal = 1 with all enables 0; it is exited only by reset.
REQ-028 Every signal not listed for a state SHALL be 0; no output is ever X.
REQ-029 imm_src SHALL be combinational from op_code, independent of state: lw and I-ALU -> I; sw -> S; beq -> B; jal -> J; lui -> U; any other opcode -> 000.
REQ-030 Latencies (cycles from entering FETCH, zero wait) SHALL be: lw 5; sw 4; R-type, I-ALU, jal and lui 4; beq 3.

Reset
REQ-031 Reset assertion SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-032 While reset = 1, SHALL hold pc_update, ir_write, reg_write, mem_write, branch and illegal at 0; the remaining outputs take FETCH values.
REQ-033 Reset mid-access (e.g. in MEMWRITE with mem_ready = 0) SHALL abort the access with no further enable pulse.
REQ-034 After deassertion, the first clock edge SHALL evaluate from FETCH.

Structure
REQ-035 Package mc_ctrl_pkg SHALL hold the state enum, the opcode constants, and the imm_src, result_src, alu_src_a and alu_src_b encodings.
REQ-036 The opcode-to-imm_src decode SHALL be sub-module mc_immdec; next-state and output logic live in mc_main_fsm.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- lw (0000011), mem_ready = 1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write = 1 only in cycle 5 with result_src = 01.
- sw (0100011), mem_ready low 3 cycles in MEMWRITE -> mem_write = 1 for 4 cycles, then FETCH; reg_write never 1.
- beq (1100011) -> 3 cycles; branch = 1 only in BRANCH, with alu_op = 01 and imm_src = 010.
- jal (1101111) -> pc_update = 1 in JAL, ALUWB next with reg_write = 1, imm_src = 011.
- lui (0110111): with EN_LUI = 1 -> LUI then ALUWB with a = 11; with EN_LUI = 0 -> TRAP, illegal = 1 and held for 10 cycles.
- Reset asserted asynchronously in MEMWRITE while mem_ready = 0 -> state = FETCH and mem_write = 0 before the next edge.
